// File: rtl/tc_mem_pkg.sv
// Shared types and helpers for the word memory bank.
// Holds the clear-sequencer state encoding and the address range check.
package tc_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/tc_mem_clear_seq.sv
// Clear sweep sequencer: walks a pointer over every word after reset or a clear request.
// Busy stays high for exactly DEPTH posedges.
module tc_mem_clear_seq
    import tc_mem_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic          r_busy;

    // Sweep FSM; a clear seen while already sweeping does not restart the pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_ptr == LAST) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr   <= r_ptr + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (i_clear) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/tc_word_memory_bank.sv
// DEPTH x WIDTH memory bank: masked save committed on negedge, two registered load ports
// on posedge, and a hardware zero sweep that owns the write port while busy.
module tc_word_memory_bank
    import tc_mem_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int OUT_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             save,
    input  logic [AW-1:0]    save_addr,
    input  logic [WIDTH-1:0] save_mask,
    input  logic [WIDTH-1:0] in,
    input  logic             load0,
    input  logic [AW-1:0]    load_addr0,
    input  logic             load1,
    input  logic [AW-1:0]    load_addr1,
    input  logic             clear,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             busy
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;

    logic             w_busy;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_nxt0;
    logic [WIDTH-1:0] w_nxt1;

    tc_mem_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (clear),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Write-port mux: the sweep has priority, so saves are dropped whenever busy is high
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_clr_addr;
        w_wdata = '0;
        if (w_clr_we) begin
            w_we    = 1'b1;
        end else if (save && addr_ok(32'(save_addr), 32'(DEPTH))) begin
            w_we    = 1'b1;
            w_waddr = save_addr;
            w_wdata = (r_mem[save_addr] & ~save_mask) | (in & save_mask);
        end else begin
            w_we    = 1'b0;
        end
    end

    // Array commit on the falling edge; nothing is written while reset is held
    always_ff @(negedge clk) begin
        if (!rst && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Next read-register values for both ports
    always_comb begin
        w_nxt0 = '0;
        w_nxt1 = '0;
        if (w_busy) begin
            w_nxt0 = '0;
            w_nxt1 = '0;
        end else begin
            if (load0) begin
                w_nxt0 = addr_ok(32'(load_addr0), 32'(DEPTH)) ? r_mem[load_addr0] : '0;
            end else begin
                w_nxt0 = (OUT_HOLD != 0) ? r_out0 : '0;
            end
            if (load1) begin
                w_nxt1 = addr_ok(32'(load_addr1), 32'(DEPTH)) ? r_mem[load_addr1] : '0;
            end else begin
                w_nxt1 = (OUT_HOLD != 0) ? r_out1 : '0;
            end
        end
    end

    // Registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out0 <= '0;
            r_out1 <= '0;
        end else begin
            r_out0 <= w_nxt0;
            r_out1 <= w_nxt1;
        end
    end

    assign out0 = r_out0;
    assign out1 = r_out1;
    assign busy = w_busy;

endmodule
